// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - prescaled second/minute/hour timebase with blink phase
module tick_generator #(
    parameter int CLK_HZ       = 256,
    parameter int SEC_PER_MIN  = 60,
    parameter int MIN_PER_HOUR = 60,
    parameter int PW           = $clog2(CLK_HZ)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clear,
    input  logic       fast,
    output logic       one_sec,
    output logic       one_min,
    output logic       one_hour,
    output logic [5:0] sec_count,
    output logic [5:0] min_count,
    output logic       half_sec
);

    // Terminal values, sized to the registers they are compared against
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
    localparam logic [5:0]    SEC_LAST = 6'(SEC_PER_MIN - 1);
    localparam logic [5:0]    MIN_LAST = 6'(MIN_PER_HOUR - 1);

    logic [PW-1:0] r_pre;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic          r_one_sec;
    logic          r_one_min;
    logic          r_one_hour;
    logic          r_half;

    logic          w_pre_last;
    logic          w_tick;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic [PW-1:0] w_pre_next;
    logic          w_half_next;

    // In fast mode the prescaler parks at 0, so leaving fast mode restarts a
    // fresh second without any extra bookkeeping.
    assign w_pre_last  = (r_pre == PRE_LAST);
    assign w_tick      = en & (fast | w_pre_last);
    assign w_sec_wrap  = w_tick & (r_sec == SEC_LAST);
    assign w_min_wrap  = w_sec_wrap & (r_min == MIN_LAST);
    assign w_pre_next  = (fast | w_pre_last) ? '0 : r_pre + PW'(1);
    assign w_half_next = ~fast & (w_pre_next < PRE_HALF);

    // Prescaler and blink phase; the phase is decoded from the next prescaler value
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_pre  <= '0;
            r_half <= 1'b1;
        end else if (en) begin
            r_pre  <= w_pre_next;
            r_half <= w_half_next;
        end
    end

    // Seconds within the minute
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_sec <= '0;
        end else if (w_tick) begin
            r_sec <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
        end
    end

    // Minutes within the hour, advanced by the minute rollover
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_min <= '0;
        end else if (w_sec_wrap) begin
            r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
        end
    end

    // One-cycle strobes; paused, cleared or non-tick edges all drop them
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_one_sec  <= 1'b0;
            r_one_min  <= 1'b0;
            r_one_hour <= 1'b0;
        end else begin
            r_one_sec  <= w_tick;
            r_one_min  <= w_sec_wrap;
            r_one_hour <= w_min_wrap;
        end
    end

    assign one_sec   = r_one_sec;
    assign one_min   = r_one_min;
    assign one_hour  = r_one_hour;
    assign sec_count = r_sec;
    assign min_count = r_min;
    assign half_sec  = r_half;

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - randomized self-checking bench for tick_generator
module tb_tick_generator;

    logic clk = 1'b0;
    logic rst_n, en, clear, fast;

    logic       o_sec  [3];
    logic       o_min  [3];
    logic       o_hour [3];
    logic [5:0] o_sc   [3];
    logic [5:0] o_mc   [3];
    logic       o_half [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Instance parameters: 0 = small test set, 1 = defaults, 2 = non-power-of-2
    int HZ  [3] = '{4, 256, 10};
    int SPM [3] = '{3, 60, 3};
    int MPH [3] = '{2, 60, 2};

    // Model state: phase within the second, seconds elapsed within the hour
    int m_ph  [3];
    int m_tot [3];
    bit m_s   [3];
    bit m_m   [3];
    bit m_h   [3];
    bit m_half[3];

    always #5 clk = ~clk;

    tick_generator #(.CLK_HZ(4), .SEC_PER_MIN(3), .MIN_PER_HOUR(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .fast(fast),
        .one_sec(o_sec[0]), .one_min(o_min[0]), .one_hour(o_hour[0]),
        .sec_count(o_sc[0]), .min_count(o_mc[0]), .half_sec(o_half[0]));

    tick_generator dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .fast(fast),
        .one_sec(o_sec[1]), .one_min(o_min[1]), .one_hour(o_hour[1]),
        .sec_count(o_sc[1]), .min_count(o_mc[1]), .half_sec(o_half[1]));

    tick_generator #(.CLK_HZ(10), .SEC_PER_MIN(3), .MIN_PER_HOUR(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .fast(fast),
        .one_sec(o_sec[2]), .one_min(o_min[2]), .one_hour(o_hour[2]),
        .sec_count(o_sc[2]), .min_count(o_mc[2]), .half_sec(o_half[2]));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model: time is a count of whole seconds plus a phase
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit tick;
            if (!rst_n || clear) begin
                m_ph[i] = 0; m_tot[i] = 0;
                m_s[i] = 0; m_m[i] = 0; m_h[i] = 0; m_half[i] = 1;
            end else if (en) begin
                if (fast) begin
                    tick = 1; m_ph[i] = 0;
                end else begin
                    tick = (m_ph[i] == HZ[i] - 1);
                    m_ph[i] = (m_ph[i] + 1) % HZ[i];
                end
                if (tick) m_tot[i] = (m_tot[i] + 1) % (SPM[i] * MPH[i]);
                m_s[i]    = tick;
                m_m[i]    = tick && (m_tot[i] % SPM[i] == 0);
                m_h[i]    = tick && (m_tot[i] == 0);
                m_half[i] = !fast && (m_ph[i] < HZ[i] / 2);
            end else begin
                m_s[i] = 0; m_m[i] = 0; m_h[i] = 0;
            end
        end
    end

    // Compare every instance against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("i%0d.one_sec", i),   32'(o_sec[i]),  32'(m_s[i]));
                check($sformatf("i%0d.one_min", i),   32'(o_min[i]),  32'(m_m[i]));
                check($sformatf("i%0d.one_hour", i),  32'(o_hour[i]), 32'(m_h[i]));
                check($sformatf("i%0d.sec_count", i), 32'(o_sc[i]),   32'(m_tot[i] % SPM[i]));
                check($sformatf("i%0d.min_count", i), 32'(o_mc[i]),   32'(m_tot[i] / SPM[i]));
                check($sformatf("i%0d.half_sec", i),  32'(o_half[i]), 32'(m_half[i]));
            end
        end
    end

    initial begin
        int first_b_sec, first_b_min, first_c_sec;
        int b_half_cnt, c_half_cnt, b_sec_cnt, b_min_cnt, c_sec_cnt;
        bit found;

        rst_n = 0; en = 1; clear = 0; fast = 0;

        // Reset held for two edges
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst.one_sec", 32'(o_sec[0]), 0);
        check("rst.sec_count", 32'(o_sc[0]), 0);
        check("rst.half_sec", 32'(o_half[0]), 1);
        rst_n = 1;

        // First tick and rollover chain, hand-computed for 4/3/2
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check($sformatf("chain.one_sec@%0d", k),  32'(o_sec[0]),  32'(k % 4 == 0));
            check($sformatf("chain.one_min@%0d", k),  32'(o_min[0]),  32'(k % 12 == 0));
            check($sformatf("chain.one_hour@%0d", k), 32'(o_hour[0]), 32'(k % 24 == 0));
            check($sformatf("chain.sec_count@%0d", k), 32'(o_sc[0]), 32'((k / 4) % 3));
        end
        check("chain.min_count@24", 32'(o_mc[0]), 0);

        // Pause with the prescaler at 2
        repeat (2) @(negedge clk);
        en = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("pause.one_sec", 32'(o_sec[0]), 0);
            check("pause.half_sec", 32'(o_half[0]), 0);
        end
        en = 1;
        @(negedge clk);
        check("resume.one_sec@1", 32'(o_sec[0]), 0);
        @(negedge clk);
        check("resume.one_sec@2", 32'(o_sec[0]), 1);
        check("resume.sec_count", 32'(o_sc[0]), 1);

        // Clear at sec_count=2, prescaler=3
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_ph[0] == 3 && m_tot[0] % 3 == 2) found = 1;
            else @(negedge clk);
        end
        check("clear.setup_found", 32'(found), 1);
        clear = 1;
        @(negedge clk);
        check("clear.one_sec", 32'(o_sec[0]), 0);
        check("clear.sec_count", 32'(o_sc[0]), 0);
        check("clear.half_sec", 32'(o_half[0]), 1);
        clear = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("clear.next@%0d", k), 32'(o_sec[0]), 32'(k == 4));
        end

        // Fast mode: seconds total is 1 on entry
        fast = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("fast.one_sec", 32'(o_sec[0]), 1);
            check("fast.half_sec", 32'(o_half[0]), 0);
            check($sformatf("fast.one_min@%0d", k), 32'(o_min[0]), 32'(k % 3 == 2));
        end
        fast = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("unfast.one_sec@%0d", k), 32'(o_sec[0]), 32'(k == 4));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) fast = ~fast;
        end

        // Long clean run for the default and non-power-of-2 periods
        @(negedge clk);
        rst_n = 0; en = 1; clear = 0; fast = 0;
        @(negedge clk);
        rst_n = 1;
        first_b_sec = 0; first_b_min = 0; first_c_sec = 0;
        b_half_cnt = 0; c_half_cnt = 0; b_sec_cnt = 0; b_min_cnt = 0; c_sec_cnt = 0;
        for (int k = 1; k <= 15360; k++) begin
            @(negedge clk);
            if (o_sec[1] === 1'b1) begin
                b_sec_cnt++;
                if (first_b_sec == 0) first_b_sec = k;
            end
            if (o_min[1] === 1'b1) begin
                b_min_cnt++;
                if (first_b_min == 0) first_b_min = k;
            end
            if (o_sec[2] === 1'b1) begin
                c_sec_cnt++;
                if (first_c_sec == 0) first_c_sec = k;
            end
            if (k <= 256 && o_half[1] === 1'b1) b_half_cnt++;
            if (k <= 10 && o_half[2] === 1'b1) c_half_cnt++;
        end
        check("dflt.first_sec", 32'(first_b_sec), 256);
        check("dflt.sec_count_total", 32'(b_sec_cnt), 60);
        check("dflt.first_min", 32'(first_b_min), 15360);
        check("dflt.min_total", 32'(b_min_cnt), 1);
        check("dflt.half_high", 32'(b_half_cnt), 128);
        check("hz10.first_sec", 32'(first_c_sec), 10);
        check("hz10.sec_total", 32'(c_sec_cnt), 1536);
        check("hz10.half_high", 32'(c_half_cnt), 5);

        // One-cycle reset mid-minute
        repeat (1000) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst.i%0d.sec_count", i), 32'(o_sc[i]), 0);
            check($sformatf("midrst.i%0d.min_count", i), 32'(o_mc[i]), 0);
            check($sformatf("midrst.i%0d.half_sec", i), 32'(o_half[i]), 1);
        end
        rst_n = 1;
        repeat (20) @(negedge clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
Parametrised timebase for the digital clock. Divides the board clock into one-cycle one_sec, one_min and one_hour strobes and exposes the running second and minute counts. It also provides a half-second blink phase for the display. The downstream time-of-day counters and display consume its outputs. Added over the earlier timebase: enable and pause, synchronous clear, a fast simulation/test mode, and an hour strobe.

Parameters:
CLK_HZ, 256, board clock cycles per second; legal range is 2 or more, and the value need not be a power of 2.
SEC_PER_MIN, 60, seconds per minute; legal range 2..64.
MIN_PER_HOUR, 60, minutes per hour; legal range 2..64.
PW, $clog2(CLK_HZ), prescaler width (derived; do not override).

Ports:
clk  in  1  board clock; everything is rising-edge.
rst_n  in  1  synchronous, active-low reset.
en  in  1  count enable; when low, all state holds.
clear  in  1  synchronous restart of the timebase.
fast  in  1  when high, every enabled cycle counts as one second.
one_sec  out  1  one-cycle second strobe.
one_min  out  1  one-cycle minute strobe.
one_hour  out  1  one-cycle hour strobe.
sec_count  out  6  seconds within the minute, 0..SEC_PER_MIN-1.
min_count  out  6  minutes within the hour, 0..MIN_PER_HOUR-1.
half_sec  out  1  blink phase; high during the first half of each second.

Behaviour:
- All outputs are registered. Reset is synchronous and active-low: rst_n sampled low at a clk edge forces the prescaler, sec_count and min_count to 0, and one_sec, one_min and one_hour to 0. half_sec then reads 1, since it is decoded from prescaler = 0.
- Priority at each edge: rst_n, then clear, then en.
- Reset or clear asserted mid-second discards the partial second. The strobes drop on that edge.
- Prescaler: PW bits wide. When en=1 and fast=0 it counts 0..CLK_HZ-1 and wraps to 0.
- The second tick is the condition prescaler = CLK_HZ-1 with en=1.
  - On the edge where the tick is true, one_sec is set to 1.
  - On every other edge, one_sec is set to 0.
  - one_sec is therefore high for exactly 1 cycle per CLK_HZ cycles.
- Latency: with en held high from reset release, one_sec is first high in the cycle after the CLK_HZ-th enabled edge.
- sec_count increments on the tick edge.
  - At SEC_PER_MIN-1 it wraps to 0, and one_min is set on that same edge.
  - one_min therefore coincides with the one_sec that rolls the minute, and sec_count reads 0 in that cycle.
- min_count increments on the edge that sets one_min.
  - At MIN_PER_HOUR-1 it wraps to 0, and one_hour is set on that same edge.
  - All three strobes can be high in the same cycle.
- Arithmetic: counters compare against parameter-1 at full width and never pass through an out-of-range value. Unused upper bits of the 6-bit counts read 0.
- en=0: prescaler and counts hold, all strobes are 0 on the next edge, and half_sec holds. Re-enabling resumes mid-second with no lost or extra cycle.
- fast=1 with en=1: the prescaler is held at 0 and every edge is a second tick.
  - one_sec stays continuously high.
  - sec_count increments every cycle.
  - one_min pulses every SEC_PER_MIN cycles.
  - half_sec = 0.
- Toggling fast mid-second restarts the prescaler from 0 when fast falls.
- half_sec = 1 when prescaler < CLK_HZ/2 (integer divide), otherwise 0. It is registered alongside the prescaler.
- clear and en may change in any cycle. There are no handshake constraints, and no multi-cycle paths.

Test Plan:
- Reset and first tick (CLK_HZ=4, SEC_PER_MIN=3, MIN_PER_HOUR=2): hold rst_n=0 for 2 edges, then release with en=1 -> all strobes 0 and counts 0 during reset; one_sec is first high in the cycle after the 4th edge, then every 4 cycles; sec_count steps 1, 2, 0.
- Rollover chain with the same parameters: run 24 cycles -> one_min is high together with the 3rd one_sec (cycle 12) and sec_count = 0; at cycle 24 one_sec, one_min and one_hour are all high and min_count = 0.
- Pause: drop en for 5 cycles when prescaler = 2 -> no strobes while paused, state frozen; the next one_sec arrives exactly 2 enabled edges after en returns.
- Clear mid-second: at sec_count = 2 and prescaler = 3, assert clear with en=1 -> the would-be strobe is suppressed, all counts are 0, and the next one_sec comes 4 enabled edges later.
- Fast mode: fast=1, en=1 with SEC_PER_MIN=3 -> one_sec is constantly 1; one_min on every 3rd cycle; half_sec = 0; after fast=0, the normal 4-cycle period resumes from prescaler 0.
- Default parameters (256/60/60), non-power-of-2 variant CLK_HZ=10, and reset held for 1 cycle mid-minute -> one_sec period is 256 (and 10 for the variant); one_min every 15360 cycles; half_sec high for 128 of 256 cycles (5 of 10 for the variant); the 1-cycle reset zeroes all counts.
